// File: rtl/dvbc_deinterleaver.sv
// dvbc_deinterleaver
//   Convolutional (Forney) byte deinterleaver for the DVB-C receive path.
//   I branches, unit depth M: branch j delays by (I-1-j)*M bytes, so the
//   interleaver + deinterleaver pair delays every byte by I*(I-1)*M bytes.
//   That delay is a whole number of PKT_LEN packets, so the byte that
//   entered at packet position 0 leaves as a genuine sync byte.
//
//   All delay lines share one RAM. Branch j sits at a fixed base address
//   and has its own circular pointer. The last branch has zero length and
//   bypasses the RAM.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   in_data_i         interleaved byte
//   in_sync_i         marks the first byte of a packet
//   in_valid_i/in_ready_o    input handshake
//   out_data_o        deinterleaved byte
//   out_sync_o        first byte of an output packet
//   out_valid_o/out_ready_i  output handshake
//   locked_o          sync lock held and delay lines primed
//   resync_o          one-cycle pulse when a misaligned sync realigns us
//
// Build option
//   DVBC_DEINT_SYNC_CHECK_EN: sync is honoured only on 0x47/0xB8 bytes.
//   In this build, four consecutive bad position-0 bytes while locked
//   drop the block back to HUNT.

module dvbc_deinterleaver #(
  parameter int I       = 12,
  parameter int M       = 17,
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 204
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sync_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sync_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              locked_o,
  output logic              resync_o
);

  localparam int RAM_DEPTH = (I-1)*I/2*M;
  localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW        = ((I-1)*M > 1) ? $clog2((I-1)*M) : 1;
  localparam int BW        = (I > 1) ? $clog2(I) : 1;
  localparam int POSW      = $clog2(PKT_LEN);
  localparam int FILL_LEN  = I*(I-1)*M;
  localparam int FW        = $clog2(FILL_LEN+1);

  function automatic int branch_len(input int j);
    return (I-1-j)*M;
  endfunction

  // Sum of the lengths of all lower-numbered branches.
  function automatic int branch_base(input int j);
    return M*(j*(I-1) - (j*(j-1))/2);
  endfunction

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_FILL   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        br_q, br_d;
  logic [POSW-1:0]      pos_q, pos_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [I-1:0][PW-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_sync_q, out_sync_d;
  logic                 out_valid_q, out_valid_d;
  logic                 resync_q, resync_d;

  logic [DATA_W-1:0]    ram [RAM_DEPTH];

  logic                 acc, sync_eff, start, misalign, realign, proc, we;
  logic                 miss_trip;
  logic [BW-1:0]        cur_br;
  logic [POSW-1:0]      cur_pos;
  logic [PW-1:0]        cur_ptr, cur_last;
  logic [AW-1:0]        cur_base, addr;
  logic [DATA_W-1:0]    rd_byte;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign acc        = in_valid_i && in_ready_o;

`ifdef DVBC_DEINT_SYNC_CHECK_EN
  logic       sync_pat;
  logic [2:0] miss_q, miss_d;

  assign sync_pat = (in_data_i == DATA_W'(8'h47)) || (in_data_i == DATA_W'(8'hB8));
  assign sync_eff = in_sync_i && sync_pat;

  // Counts consecutive bad packet-start bytes; only meaningful while locked.
  always_comb begin
    miss_d    = miss_q;
    miss_trip = 1'b0;
    if (state_q != ST_LOCKED) begin
      miss_d = '0;
    end else if (proc && cur_pos == '0) begin
      if (sync_pat) begin
        miss_d = '0;
      end else begin
        miss_d    = miss_q + 3'd1;
        miss_trip = (miss_q == 3'd3);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) miss_q <= '0;
    else       miss_q <= miss_d;
  end
`else
  assign sync_eff  = in_sync_i;
  assign miss_trip = 1'b0;
`endif

  // A sync in HUNT starts alignment; a sync off the branch-0/position-0
  // grid while running forces realignment onto that byte.
  assign start    = (state_q == ST_HUNT) && sync_eff;
  assign misalign = (state_q != ST_HUNT) && sync_eff && (pos_q != '0 || br_q != '0);
  assign realign  = start || misalign;
  assign proc     = acc && ((state_q != ST_HUNT) || sync_eff);

  assign cur_br   = realign ? '0 : br_q;
  assign cur_pos  = realign ? '0 : pos_q;
  assign cur_ptr  = ptr_q[cur_br];

  always_comb begin
    cur_base = '0;
    cur_last = '0;
    for (int j = 0; j < I-1; j++) begin
      if (cur_br == BW'(j)) begin
        cur_base = AW'(branch_base(j));
        cur_last = PW'(branch_len(j) - 1);
      end
    end
  end

  assign addr    = cur_base + AW'(cur_ptr);
  assign we      = proc && (cur_br != BW'(I-1));
  // Zero-length branch goes straight to the output register.
  assign rd_byte = (cur_br == BW'(I-1)) ? in_data_i : ram[addr];

  // Read-before-write: the async read above sees the old contents, the
  // write lands on the clock edge.
  always_ff @(posedge clk_i) begin
    if (we) ram[addr] <= in_data_i;
  end

  always_comb begin
    br_d   = br_q;
    pos_d  = pos_q;
    fill_d = fill_q;
    ptr_d  = ptr_q;
    if (proc) begin
      br_d  = (cur_br == BW'(I-1)) ? '0 : cur_br + BW'(1);
      pos_d = (cur_pos == POSW'(PKT_LEN-1)) ? '0 : cur_pos + POSW'(1);
      if (realign)                  fill_d = FW'(1);
      else if (state_q == ST_FILL)  fill_d = fill_q + FW'(1);
    end
    if (we) ptr_d[cur_br] = (cur_ptr == cur_last) ? '0 : cur_ptr + PW'(1);
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_HUNT;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (proc) state_d = ST_FILL;
      ST_FILL:   if (proc && !misalign && fill_q == FW'(FILL_LEN-1)) state_d = ST_LOCKED;
      ST_LOCKED: begin
        if (proc && misalign)       state_d = ST_FILL;
        else if (proc && miss_trip) state_d = ST_HUNT;
      end
      default:   state_d = ST_HUNT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked_o = (state_q == ST_LOCKED);
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sync_d  = out_sync_q;
    out_valid_d = out_valid_q;
    resync_d    = acc && misalign;
    if (proc) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_byte;
      out_sync_d  = (cur_pos == '0);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_q        <= '0;
      pos_q       <= '0;
      fill_q      <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sync_q  <= 1'b0;
      out_valid_q <= 1'b0;
      resync_q    <= 1'b0;
    end else begin
      br_q        <= br_d;
      pos_q       <= pos_d;
      fill_q      <= fill_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sync_q  <= out_sync_d;
      out_valid_q <= out_valid_d;
      resync_q    <= resync_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_sync_o  = out_sync_q;
  assign out_valid_o = out_valid_q;
  assign resync_o    = resync_q;

endmodule

// File: tb/tb_dvbc_deinterleaver.sv
module tb_dvbc_deinterleaver;
  localparam int I   = 12;
  localparam int M   = 17;
  localparam int PKT = 204;
  localparam int DLY = I*(I-1)*M;   // 2244 bytes end to end

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] in_data_i = 8'h00;
  logic       in_sync_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_sync_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic       locked_o;
  logic       resync_o;

  dvbc_deinterleaver dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(in_data_i), .in_sync_i(in_sync_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_sync_o(out_sync_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .locked_o(locked_o), .resync_o(resync_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Original (pre-interleaver) stream; packets start with 0x47.
  logic [7:0] s_mem [0:8191];
  int  drv_g = -1;        // stream index of the byte on the bus
  logic rnd_rdy = 1'b0;
  int  rs_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Modulator-side interleaver: branch j = g mod I delays by j*M*I stream bytes.
  function automatic logic [7:0] ilv(input int g);
    int j;
    j = g % I;
    if (g - j*M*I < 0) return 8'h00;
    return s_mem[g - j*M*I];
  endfunction

  // ---------------- behavioural reference ----------------
  typedef enum {M_HUNT, M_FILL, M_LOCK} mst_e;
  mst_e m_st;
  int   m_pos, m_br, m_seg, m_fill, m_miss;
  logic e_valid, e_sync, e_locked, e_resync, e_known;
  logic [7:0] e_data;
  int   e_seg;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_st = M_HUNT; m_pos = 0; m_br = 0; m_seg = 0; m_fill = 0; m_miss = 0;
      e_valid = 0; e_sync = 0; e_locked = 0; e_resync = 0; e_known = 0;
      e_data = 8'h00; e_seg = 0;
    end else begin : step
      logic acc, sy, pat;
      acc = in_valid_i && (!e_valid || out_ready_i);
      e_resync = 1'b0;
      if (e_valid && out_ready_i) e_valid = 1'b0;
      if (acc) begin
        pat = (in_data_i == 8'h47) || (in_data_i == 8'hB8);
        sy  = in_sync_i;
`ifdef DVBC_DEINT_SYNC_CHECK_EN
        sy  = sy && pat;
`endif
        if (m_st != M_HUNT || sy) begin
          if (sy && (m_st == M_HUNT || m_pos != 0 || m_br != 0)) begin
            if (m_st != M_HUNT) e_resync = 1'b1;
            m_st = M_FILL; m_pos = 0; m_br = 0; m_seg = 0; m_fill = 0; m_miss = 0;
          end
          e_valid = 1'b1;
          e_sync  = (m_pos == 0);
          e_seg   = m_seg;
          // Once the segment is DLY bytes old the output is the source
          // stream delayed by exactly DLY bytes.
          e_known = (m_seg >= DLY) && (drv_g - DLY >= 0);
          if (e_known) e_data = s_mem[drv_g - DLY];
          m_seg++;
          if (m_st == M_FILL) begin
            m_fill++;
            if (m_fill == DLY) m_st = M_LOCK;
          end else if (m_st == M_LOCK && m_pos == 0) begin
`ifdef DVBC_DEINT_SYNC_CHECK_EN
            if (pat) m_miss = 0;
            else begin
              m_miss++;
              if (m_miss == 4) m_st = M_HUNT;
            end
`endif
          end
          m_pos = (m_pos + 1) % PKT;
          m_br  = (m_br + 1) % I;
        end
      end
      e_locked = (m_st == M_LOCK);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_locked = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_locked = 1'b0;
    end else begin
      chk("in_ready", int'(in_ready_o), int'(!e_valid || out_ready_i));
      chk("out_valid", int'(out_valid_o), int'(e_valid));
      chk("locked", int'(locked_o), int'(e_locked));
      chk("resync", int'(resync_o), int'(e_resync));
      if (e_valid) begin
        chk("out_sync", int'(out_sync_o), int'(e_sync));
        if (e_known) chk("out_data", int'(out_data_o), int'(e_data));
        if (e_seg == DLY) begin
          chk("first_locked_byte", int'(out_data_o), 32'h47);
          chk("first_locked_sync", int'(out_sync_o), 1);
        end
      end
      if (locked_o && !prev_locked) chk("lock_after_bytes", m_seg, 2244);
      if (resync_o) rs_count++;
      prev_locked = locked_o;
    end
  end

  always @(posedge clk_i) begin
    #1;
    out_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic sy, input int g);
    logic r;
    int   guard;
    if ($urandom_range(0, 99) < 15) begin
      in_valid_i = 1'b0;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b1; in_data_i = d; in_sync_i = sy; drv_g = g;
    guard = 0;
    do begin
      @(negedge clk_i); r = in_ready_o;
      @(posedge clk_i); #1;
      guard++;
    end while (!r && guard < 200);
    if (!r) begin
      checks++; errors++;
      $display("FAIL accept_timeout: byte %0d not accepted in 200 cycles", g);
    end
    in_valid_i = 1'b0; in_sync_i = 1'b0;
  endtask

  task automatic run(input int g0, input int g1);
    for (int g = g0; g < g1; g++) send(ilv(g), (g % PKT) == 0, g);
  endtask

  initial begin
    for (int k = 0; k < 8192; k++) s_mem[k] = (k % PKT == 0) ? 8'h47 : 8'($urandom);

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", int'(out_valid_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_data", int'(out_data_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Preamble with no sync: everything discarded.
    for (int k = 0; k < 30; k++) send(8'($urandom), 1'b0, -1);
    chk("hunt_no_valid", int'(out_valid_o), 0);
    chk("hunt_no_lock", int'(locked_o), 0);

    // 20 packets, downstream always ready.
    run(0, 20*PKT);
    chk("locked_after_20pkt", int'(locked_o), 1);

    // 10 packets with random backpressure.
    rnd_rdy = 1'b1;
    run(20*PKT, 30*PKT);
    rnd_rdy = 1'b0;

    // Fresh stream whose sync arrives at position 100.
    run(30*PKT, 30*PKT + 100);
    rs_count = 0;
    run(0, 13*PKT);
    chk("resync_pulses", rs_count, 1);
    chk("relocked", int'(locked_o), 1);

    // Asynchronous reset mid-packet, then carry on with the same stream.
    run(13*PKT, 13*PKT + 50);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid_o), 0);
    chk("arst_locked", int'(locked_o), 0);
    chk("arst_sync", int'(out_sync_o), 0);
    chk("arst_data", int'(out_data_o), 0);
    chk("arst_resync", int'(resync_o), 0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    @(posedge clk_i); #1;
    run(13*PKT + 50, 26*PKT);
    chk("locked_after_reset", int'(locked_o), 1);

`ifdef DVBC_DEINT_SYNC_CHECK_EN
    for (int p = 27; p <= 29; p++) s_mem[p*PKT] = 8'h00;
    for (int p = 32; p <= 35; p++) s_mem[p*PKT] = 8'h00;
    run(26*PKT, 30*PKT + 10);
    chk("three_misses_keep_lock", int'(locked_o), 1);
    run(30*PKT + 10, 35*PKT + 1);
    chk("fourth_miss_drops_lock", int'(locked_o), 0);
    run(35*PKT + 1, 37*PKT);
    chk("refill_not_locked", int'(locked_o), 0);
`endif

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dvbc_deinterleaver.md
Name: dvbc_deinterleaver

Overview:
- Convolutional (Forney) byte deinterleaver for the DVB-C path, per EN 300 429: I=12 branches, unit depth M=17.
- It is the inverse of the modulator-side interleaver and sits at the receive/loopback end, after the QAM demapper and before the RS(204,188) decoder.
- Branch j delays by (I-1-j)*M bytes. The total end-to-end delay (interleaver plus deinterleaver) is I*(I-1)*M = 2244 bytes, which is exactly 11 packets of 204 bytes.

Parameters:
- I, 12, number of branches.
- M, 17, unit delay in bytes.
- DATA_W, 8, byte width.
- PKT_LEN, 204, RS packet length; I must divide PKT_LEN.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset: asynchronous, active-high.
- in_data_i, in, DATA_W, interleaved byte.
- in_sync_i, in, 1, marks the sync byte (first byte of a 204-byte packet).
- in_valid_i, in, 1, input byte valid.
- in_ready_o, out, 1, input accept.
- out_data_o, out, DATA_W, deinterleaved byte.
- out_sync_o, out, 1, marks the first byte of an output packet.
- out_valid_o, out, 1, output valid.
- out_ready_i, in, 1, downstream accept.
- locked_o, out, 1, sync lock acquired and delay lines primed.
- resync_o, out, 1, one-cycle pulse when a misaligned sync forces realignment.

Behaviour:
- Reset values: out_data_o=0, out_sync_o=0, out_valid_o=0, locked_o=0, resync_o=0. Branch counter, position counter, fill counter and all branch pointers are 0. State is HUNT. RAM contents are not reset.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - in_ready_o = !out_valid_o || out_ready_i.
  - out_* stay stable while out_valid_o=1 and out_ready_i=0.
- Storage:
  - One RAM of (I-1)*I/2*M = 1122 bytes. Branch j occupies a fixed base address sum_{k<j} (I-1-k)*M and has length L_j = (I-1-j)*M.
  - Each branch has its own pointer (8 bits at default parameters).
  - Branch I-1 (L=0) is a combinational bypass into the output register.
- Per accepted byte on branch j:
  - Read the RAM at base_j + ptr_j (read-before-write), write in_data_i to the same address, then ptr_j = (ptr_j == L_j-1) ? 0 : ptr_j+1.
  - The output register loads the read byte one cycle later.
  - Latency from input accept to out_valid_o is 1 cycle.
- Branch counter: increments per accepted byte and wraps from I-1 to 0.
- Position counter: 0..PKT_LEN-1, increments per accepted byte and wraps at PKT_LEN.
- State machine:
  - HUNT:
    - Bytes are accepted and discarded: no RAM write, out_valid_o stays 0.
    - An accepted byte with in_sync_i=1 sets branch=0 and position=0, processes that byte on branch 0, and moves to FILL.
  - FILL:
    - Bytes are processed normally; out_valid_o=1 for each processed byte.
    - The fill counter counts accepted bytes. When it reaches 2244, the state moves to LOCKED and locked_o=1.
  - LOCKED: normal operation.
- Output sync: out_sync_o = 1 on the output byte whose input had position==0.
  - Because the delay is a multiple of PKT_LEN, this byte is the true deinterleaved sync byte.
- Misaligned sync:
  - Condition: in FILL or LOCKED, an accepted byte has in_sync_i=1 but position!=0 or branch!=0.
  - Response: pulse resync_o, force branch=0 and position=0 for that byte, clear the fill counter, enter FILL, and drop locked_o.
  - Branch pointers are not cleared.
- Sync not asserted at position 0: tolerated, no action.
- Simultaneous input accept and output stall is impossible because in_ready_o is low during a stall.
- Reset mid-operation: all control state returns to HUNT immediately (async). A partially filled RAM is ignored because FILL re-primes it.

Optional Feature:
- Macro DVBC_DEINT_SYNC_CHECK_EN.
- Defined:
  - in_sync_i is honoured only if in_data_i is 8'h47 or 8'hB8; otherwise it is treated as 0.
  - In LOCKED, a position-0 byte that is not 0x47/0xB8 increments an internal 3-bit miss counter.
  - On the 4th consecutive miss, return to HUNT and drop locked_o.
- Undefined: in_sync_i is trusted as-is and there is no miss counter.

Test Plan:
- Reset, then stream 20 packets with sync 0x47 through the reference interleaver model.
  - Expect locked_o=1 after exactly 2244 accepted bytes.
  - Expect output to equal the original stream delayed by 2244 bytes, with out_sync_o on every 0x47.
- Bytes before the first in_sync_i: expect no out_valid_o and no RAM writes. The first sync enters FILL.
- Toggle out_ready_i randomly at 50% during a 10-packet stream: expect no data loss or duplication and outputs held during stalls.
- Inject in_sync_i at position 100 while LOCKED: expect a one-cycle resync_o pulse, locked_o=0, and relock 2244 bytes later.
- Assert rst_i asynchronously mid-packet: expect all outputs 0 in the same cycle and state HUNT.
- With DVBC_DEINT_SYNC_CHECK_EN defined, corrupt 4 consecutive sync bytes to 0x00: expect locked_o to fall after the 4th. With 3 corrupted, expect locked_o to stay 1.
